// File: rtl/ex_mem_skid.sv
// ex_mem_skid
// -----------
// EX->MEM pipeline register with a valid/ready handshake and a 2-entry skid
// buffer. The main register drives the mem_* outputs. The skid register takes
// one extra EX result when MEM stalls, so EX never loses a result it handed
// over. Every output comes straight from a register or from the state, so
// mem_ready has no combinational path to ex_ready.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             discard every buffered entry (mispredict/exception)
//   ex_valid/ex_ready handshake with EX; ex_* is the EX result payload
//   mem_valid/mem_ready handshake with MEM; mem_* is the head entry payload
//   occupancy         number of entries held (0, 1 or 2)
module ex_mem_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [OP_W-1:0]   ex_aluop,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_sdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [OP_W-1:0]   mem_aluop,
  output logic [ADDR_W-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_sdata,
  output logic [1:0]        occupancy
);

  localparam int PAY_W = OP_W + ADDR_W + 1 + 2 * DATA_W;

  // EMPTY: nothing held; FULL: main only; SKID: main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PAY_W-1:0] ex_pay;
  logic [PAY_W-1:0] main_q;
  logic [PAY_W-1:0] skid_q;
  logic             accept;
  logic             consume;
  logic             load_main_ex;
  logic             load_main_skid;
  logic             load_skid;
  logic             clear_main;

  assign ex_pay = {ex_aluop, ex_wd, ex_wreg, ex_wdata, ex_sdata};
  assign {mem_aluop, mem_wd, mem_wreg, mem_wdata, mem_sdata} = main_q;

  // Handshake status depends on state alone; nothing here looks at mem_ready.
  assign ex_ready  = (state != SKID);
  assign mem_valid = (state != EMPTY);
  assign accept    = ex_valid && ex_ready;
  assign consume   = mem_valid && mem_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next state and payload-movement strobes. The main payload is cleared
  // whenever main goes invalid so mem_* reads all zero while mem_valid is low.
  always_comb begin
    state_next     = state;
    load_main_ex   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clear_main     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next   = FULL;
          load_main_ex = 1'b1;
        end
      end
      FULL: begin
        if (accept && consume) begin
          load_main_ex = 1'b1;
        end else if (accept) begin
          state_next = SKID;
          load_skid  = 1'b1;
        end else if (consume) begin
          state_next = EMPTY;
          clear_main = 1'b1;
        end
      end
      SKID: begin
        // ex_ready is low here, so only a consume can happen.
        if (consume) begin
          state_next     = FULL;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
        clear_main = 1'b1;
      end
    endcase
  end

  // rst and flush have identical effect, so they share one branch.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_ex) begin
        main_q <= ex_pay;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end else if (clear_main) begin
        main_q <= '0;
      end
      if (load_skid) begin
        skid_q <= ex_pay;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid
// --------------
// Bench for ex_mem_skid. A scoreboard queue receives every item EX hands
// over and is checked against the mem_* head on every cycle; each scenario
// task additionally checks the cycle-exact values it is about.
module tb_ex_mem_skid;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] sdata;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [7:0]  ex_aluop = '0;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0;
  logic [31:0] ex_sdata = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_aluop;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_sdata;
  logic [1:0]  occupancy;

  int    checks = 0;
  int    failures = 0;
  bit    sb_en = 1'b0;
  item_t sb[$];

  ex_mem_skid #(.DATA_W(32), .ADDR_W(5), .OP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_aluop  (ex_aluop),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .ex_wdata  (ex_wdata),
    .ex_sdata  (ex_sdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_aluop (mem_aluop),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_sdata (mem_sdata),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Scoreboard: the model occupancy is the queue depth. At each negedge the
  // DUT outputs are compared, then the queue is updated with what will
  // happen at the coming posedge.
  always @(negedge clk) begin
    if (sb_en) begin
      int    n;
      item_t got;
      item_t exp;
      n   = sb.size();
      got = {mem_aluop, mem_wd, mem_wreg, mem_wdata, mem_sdata};
      exp = (n > 0) ? sb[0] : '0;
      checks++;
      if (occupancy !== 2'(n)) begin
        failures++;
        $display("[TB] FAIL sb_occupancy: got %0d expected %0d", occupancy, n);
      end
      checks++;
      if (mem_valid !== (n > 0)) begin
        failures++;
        $display("[TB] FAIL sb_mem_valid: got %b expected %b", mem_valid, n > 0);
      end
      checks++;
      if (ex_ready !== (n < 2)) begin
        failures++;
        $display("[TB] FAIL sb_ex_ready: got %b expected %b", ex_ready, n < 2);
      end
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL sb_payload: got %h expected %h", got, exp);
      end
      if (rst || flush) begin
        sb.delete();
      end else begin
        if (mem_ready && n > 0) void'(sb.pop_front());
        if (ex_valid && n < 2) sb.push_back({ex_aluop, ex_wd, ex_wreg, ex_wdata, ex_sdata});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // The opcode is derived from wd so it is non-zero and distinct per item.
  task automatic applyStimulus(input logic v, input logic [4:0] wd,
                               input logic [31:0] wdata, input logic mr);
    ex_valid  = v;
    ex_wd     = wd;
    ex_aluop  = 8'h10 + {3'b000, wd};
    ex_wreg   = 1'b1;
    ex_wdata  = wdata;
    ex_sdata  = ~wdata;
    mem_ready = mr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    checks++;
    if (mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_valid: got %b expected 0", mem_valid); end
    checks++;
    if (mem_wreg !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_wreg: got %b expected 0", mem_wreg); end
    checks++;
    if (mem_wd !== 5'd0) begin failures++; $display("[TB] FAIL reset_mem_wd: got %0d expected 0", mem_wd); end
    checks++;
    if (mem_aluop !== 8'd0) begin failures++; $display("[TB] FAIL reset_mem_aluop: got %h expected 00", mem_aluop); end
    checks++;
    if (occupancy !== 2'd0) begin failures++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
    checks++;
    if (ex_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ex_ready: got %b expected 1", ex_ready); end
    sb_en = 1'b1;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i * 16), 1'b1);
      next_cycle();
      checks++;
      if (mem_valid !== 1'b1 || mem_wd !== 5'(i)) begin
        failures++;
        $display("[TB] FAIL stream_head: got valid=%b wd=%0d expected valid=1 wd=%0d", mem_valid, mem_wd, i);
      end
      checks++;
      if (occupancy !== 2'd1 || ex_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stream_occ: got occ=%0d ex_ready=%b expected occ=1 ex_ready=1", occupancy, ex_ready);
      end
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    next_cycle();
  endtask

  task automatic test_backpressure();
    applyStimulus(1'b1, 5'd5, 32'hAA, 1'b0);
    next_cycle();
    applyStimulus(1'b1, 5'd6, 32'hBB, 1'b0);
    next_cycle();
    checks++;
    if (occupancy !== 2'd2 || ex_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_full: got occ=%0d ex_ready=%b expected occ=2 ex_ready=0", occupancy, ex_ready);
    end
    // Item 7 is offered while ex_ready is low; EX keeps holding it.
    applyStimulus(1'b1, 5'd7, 32'hCC, 1'b0);
    next_cycle();
    checks++;
    if (occupancy !== 2'd2 || mem_wd !== 5'd5 || mem_wdata !== 32'hAA) begin
      failures++;
      $display("[TB] FAIL bp_hold: got occ=%0d wd=%0d wdata=%h expected occ=2 wd=5 wdata=aa", occupancy, mem_wd, mem_wdata);
    end
    applyStimulus(1'b1, 5'd7, 32'hCC, 1'b1);
    next_cycle();
    checks++;
    if (mem_wd !== 5'd6 || mem_wdata !== 32'hBB || occupancy !== 2'd1) begin
      failures++;
      $display("[TB] FAIL bp_second: got wd=%0d wdata=%h occ=%0d expected wd=6 wdata=bb occ=1", mem_wd, mem_wdata, occupancy);
    end
    next_cycle();
    checks++;
    if (mem_wd !== 5'd7 || mem_wdata !== 32'hCC || occupancy !== 2'd1) begin
      failures++;
      $display("[TB] FAIL bp_third: got wd=%0d wdata=%h occ=%0d expected wd=7 wdata=cc occ=1", mem_wd, mem_wdata, occupancy);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    next_cycle();
    checks++;
    if (occupancy !== 2'd0 || mem_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_drain: got occ=%0d valid=%b expected occ=0 valid=0", occupancy, mem_valid);
    end
  endtask

  task automatic test_flush_skid();
    applyStimulus(1'b1, 5'd11, 32'h1111, 1'b0);
    next_cycle();
    applyStimulus(1'b1, 5'd12, 32'h2222, 1'b0);
    next_cycle();
    applyStimulus(1'b1, 5'd9, 32'h9999, 1'b0);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    checks++;
    if (occupancy !== 2'd0 || mem_valid !== 1'b0 || ex_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_state: got occ=%0d valid=%b ex_ready=%b expected occ=0 valid=0 ex_ready=1", occupancy, mem_valid, ex_ready);
    end
    checks++;
    if ({mem_aluop, mem_wd, mem_wreg, mem_wdata, mem_sdata} !== '0) begin
      failures++;
      $display("[TB] FAIL flush_payload: got wd=%0d aluop=%h wreg=%b wdata=%h sdata=%h expected all zero", mem_wd, mem_aluop, mem_wreg, mem_wdata, mem_sdata);
    end
    next_cycle();
    checks++;
    if (mem_valid !== 1'b0 || mem_wd === 5'd9) begin
      failures++;
      $display("[TB] FAIL flush_dropped: got valid=%b wd=%0d expected valid=0 wd=0", mem_valid, mem_wd);
    end
  endtask

  task automatic test_accept_consume();
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0);
    next_cycle();
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b1);
    next_cycle();
    checks++;
    if (mem_wd !== 5'd4 || occupancy !== 2'd1 || mem_wdata !== 32'h44) begin
      failures++;
      $display("[TB] FAIL accept_consume: got wd=%0d occ=%0d wdata=%h expected wd=4 occ=1 wdata=44", mem_wd, occupancy, mem_wdata);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    next_cycle();
  endtask

  task automatic test_reset_mid_stall();
    applyStimulus(1'b1, 5'd20, 32'hA0A0, 1'b0);
    next_cycle();
    applyStimulus(1'b1, 5'd21, 32'hA1A1, 1'b0);
    next_cycle();
    checks++;
    if (occupancy !== 2'd2) begin
      failures++;
      $display("[TB] FAIL stall_fill: got occ=%0d expected 2", occupancy);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    checks++;
    if (mem_valid !== 1'b0 || occupancy !== 2'd0 || ex_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_reset_state: got valid=%b occ=%0d ex_ready=%b expected 0 0 1", mem_valid, occupancy, ex_ready);
    end
    checks++;
    if ({mem_aluop, mem_wd, mem_wreg, mem_wdata, mem_sdata} !== '0) begin
      failures++;
      $display("[TB] FAIL stall_reset_payload: got wd=%0d wdata=%h expected all zero", mem_wd, mem_wdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    $urandom, 1'($urandom_range(0, 1)));
      next_cycle();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    repeat (3) next_cycle();
    checks++;
    if (occupancy !== 2'd0) begin
      failures++;
      $display("[TB] FAIL random_drain: got occ=%0d expected 0", occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_skid();
    test_accept_consume();
    test_reset_mid_stall();
    test_back_to_back();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover: got %0d items expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Downstream end of the EX-stage pipeline interface. Registers EX results toward MEM.
- Unlike a free-running stage register, it uses a valid/ready handshake. A 2-entry skid buffer lets MEM stall on memory latency without losing an EX result.
- Sits between ex and mem. Stall/flush control is driven by ctrl.

Parameters:
- DATA_W, 32, width of register/data/address buses.
- ADDR_W, 5, register-file address width.
- OP_W, 8, ALU opcode width; NOP opcode = all zeros.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset: synchronous, active-high.
- flush  in  1  discard all buffered entries (branch mispredict/exception).
- ex_valid  in  1  EX presents a valid result this cycle.
- ex_ready  out  1  block can accept an EX result this cycle.
- ex_aluop  in  OP_W  ALU opcode (MEM uses it for load/store type).
- ex_wd  in  ADDR_W  destination register.
- ex_wreg  in  1  register write enable.
- ex_wdata  in  DATA_W  ALU result / effective address.
- ex_sdata  in  DATA_W  store data (rs2 value).
- mem_valid  out  1  head entry valid toward MEM.
- mem_ready  in  1  MEM consumes the head entry this cycle.
- mem_aluop  out  OP_W  head entry opcode.
- mem_wd  out  ADDR_W  head entry destination.
- mem_wreg  out  1  head entry write enable.
- mem_wdata  out  DATA_W  head entry result.
- mem_sdata  out  DATA_W  head entry store data.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main register (drives mem_* outputs) plus skid register. Each has a valid bit.
- State is encoded as EMPTY (0 entries), FULL (main only) or SKID (main + skid).
- Outputs are driven directly from registers or from state. There is no combinational path from mem_ready to ex_ready.
- ex_ready = 1 in EMPTY and FULL; 0 in SKID.
- mem_valid = 1 in FULL and SKID.
- occupancy = 0 / 1 / 2 for EMPTY / FULL / SKID.
- Accept event: ex_valid && ex_ready. Consume event: mem_valid && mem_ready.
- Transitions at posedge:
  - EMPTY, accept -> FULL, main <= ex_*.
  - FULL, accept && consume -> FULL, main <= ex_* (zero-bubble throughput, 1 per cycle).
  - FULL, accept only -> SKID, skid <= ex_*, main unchanged.
  - FULL, consume only -> EMPTY.
  - SKID, consume -> FULL, main <= skid.
  - No event -> state and payload hold.
- Whenever main becomes invalid, main payload is zeroed: aluop=0, wd=0, wreg=0, wdata=0, sdata=0. Hence mem_wreg=0 whenever mem_valid=0.
- Skid payload is don't-care when invalid; a zero-reset is acceptable.
- Latency: an accepted entry appears on mem_* at the next posedge when the block was EMPTY, or when FULL with a concurrent consume. Otherwise it waits behind older entries. Ordering is strictly FIFO.
- mem_* outputs are stable while mem_valid=1 && mem_ready=0.
- flush: next state EMPTY and all payload zeroed. A concurrent accept is dropped. A concurrent consume still counts as completed by MEM. flush has priority over all transitions.
- rst: same effect as flush. Priority is rst > flush > handshake. After reset: mem_valid=0, every mem_* output=0, occupancy=0, ex_ready=1. Reset asserted mid-stall discards both entries.
- ex_valid with ex_ready=0 is ignored; EX must hold the item and retry. mem_ready while mem_valid=0 has no effect.

Test Plan:
- Reset -> mem_valid=0, mem_wreg=0, mem_wd=0, mem_aluop=0, occupancy=0, ex_ready=1.
- Streaming: mem_ready=1; ex_valid=1 for 4 cycles with wd=1..4, wdata=0x10..0x40 -> mem_valid from cycle 1; wd 1,2,3,4 on consecutive cycles; occupancy stays 1; ex_ready never drops.
- Backpressure: mem_ready=0; send wd=5/wdata=0xAA then wd=6/wdata=0xBB -> occupancy 2, ex_ready=0. A third item wd=7 is offered and held by EX, so it is not accepted. Raise mem_ready -> outputs wd 5, 6, 7 in order with no loss or duplication.
- Flush in SKID: fill 2 entries, assert flush alongside ex_valid (wd=9) -> next cycle occupancy=0, mem_valid=0, all mem_*=0, ex_ready=1. wd=9 never appears.
- Simultaneous accept+consume in FULL: main wd=3, ex wd=4, mem_ready=1 -> next cycle mem_wd=4, occupancy=1.
- Reset mid-stall: occupancy=2, rst=1 for one cycle while mem_ready=0 -> all outputs at reset values the following cycle.
